// File: rtl/spi_bank_arbiter.sv
// Byte-bank arbiter: SPI reads, a pending SPI write slot and host beats share one port.
// Optional ARB_HOST_LOCK_EN adds host_lock / spi_wr_blocked to discard SPI writes.
module spi_bank_arbiter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_addr_v,
  output logic [7:0]        spi_rdata,
  input  logic [7:0]        spi_wdata,
  input  logic              spi_wdata_v,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [1:0]        host_write_n,
  input  logic [1:0]        host_read_n,
  output logic [31:0]       host_rdata,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
`ifdef ARB_HOST_LOCK_EN
  input  logic              host_lock,
  output logic              spi_wr_blocked,
`endif
  output logic              busy,
  output logic              spi_ovf
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt_q;
  logic              pend_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [7:0]        pdata_q;
  logic              rr_spi_q;
  logic [31:0]       rdata_q;
  logic              ovf_q;

  logic              req_wr, req_rd, req;
  logic [1:0]        req_w, req_last;
  logic              host_pend, spi_gnt, host_gnt, cap;
  logic [ADDR_W-1:0] beat_addr;

  assign req_wr = host_write_n != 2'b11;
  assign req_rd = host_read_n != 2'b11;
  assign req    = req_wr | req_rd;
  assign req_w  = req_wr ? host_write_n : host_read_n;

  always_comb begin
    req_last = 2'd3;
    unique case (1'b1)
      req_w == 2'b00: req_last = 2'd0;
      req_w == 2'b01: req_last = 2'd1;
      default:        req_last = 2'd3;
    endcase
  end

  assign host_pend = state_q == BEAT;
  assign spi_gnt   = !spi_addr_v && pend_q && (!host_pend || !rr_spi_q);
  assign host_gnt  = !spi_addr_v && !spi_gnt && host_pend;
  assign beat_addr = addr_q + ADDR_W'(cnt_q);

`ifdef ARB_HOST_LOCK_EN
  assign cap = spi_wdata_v && !host_lock;
`else
  assign cap = spi_wdata_v;
`endif

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
    unique case (1'b1)
      spi_addr_v: mem_addr = spi_addr;
      spi_gnt: begin
        mem_addr  = paddr_q;
        mem_wdata = pdata_q;
      end
      host_gnt: mem_addr = beat_addr;
      default: mem_addr = addr_q;
    endcase
  end

  // Gated by rstb so an abandoned transaction writes nothing on the reset edge.
  assign mem_we     = rstb && ena && (spi_gnt || (host_gnt && we_q));
  assign spi_rdata  = mem_rdata;
  assign host_rdata = rdata_q;
  assign host_ready = state_q == DONE;
  assign busy       = (state_q != IDLE) || pend_q;
  assign spi_ovf    = ovf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = BEAT;
      BEAT: if (host_gnt && cnt_q == last_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      last_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else if (ena) begin
      if (state_q == IDLE && req) begin
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
        we_q    <= req_wr;
        last_q  <= req_last;
        cnt_q   <= '0;
        rdata_q <= '0;
      end else if (host_gnt) begin
        if (!we_q) rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rdata;
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Pending slot: a fresh capture wins over the grant that empties it.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      pend_q   <= 1'b0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      rr_spi_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ena) begin
      if (spi_gnt) rr_spi_q <= 1'b1;
      else if (host_gnt) rr_spi_q <= 1'b0;
      if (cap) begin
        pend_q  <= 1'b1;
        paddr_q <= spi_addr;
        pdata_q <= spi_wdata;
        if (pend_q && !spi_gnt) ovf_q <= 1'b1;
      end else if (spi_gnt) begin
        pend_q <= 1'b0;
      end
    end
  end

`ifdef ARB_HOST_LOCK_EN
  logic blk_q;
  always_ff @(posedge clk) begin
    if (!rstb) blk_q <= 1'b0;
    else if (ena && spi_wdata_v && host_lock) blk_q <= 1'b1;
  end
  assign spi_wr_blocked = blk_q;
`endif

endmodule

// File: tb/tb_spi_bank_arbiter.sv
// Bench for spi_bank_arbiter: queue-based transaction model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_spi_bank_arbiter;
  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        ena = 1'b1;
  logic [5:0]  spi_addr = '0;
  logic        spi_addr_v = 1'b0;
  logic [7:0]  spi_rdata;
  logic [7:0]  spi_wdata = '0;
  logic        spi_wdata_v = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [1:0]  host_write_n = 2'b11;
  logic [1:0]  host_read_n = 2'b11;
  logic [31:0] host_rdata;
  logic        host_ready;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        spi_ovf;

  spi_bank_arbiter #(.ADDR_W(6)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .spi_addr(spi_addr), .spi_addr_v(spi_addr_v), .spi_rdata(spi_rdata),
    .spi_wdata(spi_wdata), .spi_wdata_v(spi_wdata_v),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_write_n(host_write_n), .host_read_n(host_read_n),
    .host_rdata(host_rdata), .host_ready(host_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  logic [7:0] bank [64] = '{default: 8'h00};
  assign mem_rdata = bank[mem_addr];
  always @(posedge clk) if (mem_we) bank[mem_addr] <= mem_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: host job as a queue of byte beats, one SPI slot.
  logic [7:0]  sb [64] = '{default: 8'h00};
  logic [5:0]  q_addr [$];
  logic [7:0]  q_data [$];
  bit          m_wr, m_active, m_done, m_pend, m_rr_spi, m_ovf;
  logic [5:0]  m_base, m_paddr;
  logic [7:0]  m_pdata;
  logic [31:0] m_rdata;
  int          m_k;
  bit          started = 0;

  task automatic model_reset();
    q_addr.delete(); q_data.delete();
    m_wr = 0; m_active = 0; m_done = 0; m_pend = 0;
    m_rr_spi = 0; m_ovf = 0; m_base = '0; m_paddr = '0;
    m_pdata = '0; m_rdata = '0; m_k = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit hp, sg, hg, pp, wr, ewe;
    logic [5:0] ea;
    int n;
    logic [1:0] w;
    if (started) begin
      hp  = q_addr.size() > 0;
      sg  = !spi_addr_v && m_pend && (!hp || !m_rr_spi);
      hg  = !spi_addr_v && !sg && hp;
      ewe = rstb && ena && (sg || (hg && m_wr));
      ea  = spi_addr_v ? spi_addr : sg ? m_paddr : hg ? q_addr[0] : m_base;
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      if (ewe) chk("mem_wdata", 32'(mem_wdata), 32'(sg ? m_pdata : q_data[0]));
      if (spi_addr_v) chk("spi_rdata", 32'(spi_rdata), 32'(sb[spi_addr]));
      chk("host_ready", 32'(host_ready), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_active || m_done || m_pend));
      chk("host_rdata", host_rdata, m_rdata);
      chk("spi_ovf", 32'(spi_ovf), 32'(m_ovf));
      if (!rstb) begin
        model_reset();
      end else if (ena) begin
        pp = m_pend;
        if (m_done) begin
          m_done = 0;
        end else if (!m_active && (host_write_n != 2'b11 || host_read_n != 2'b11)) begin
          wr = host_write_n != 2'b11;
          w  = wr ? host_write_n : host_read_n;
          n  = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
          for (int k = 0; k < n; k++) begin
            q_addr.push_back(6'(host_addr + 6'(k)));
            q_data.push_back(wr ? host_wdata[8*k +: 8] : 8'h00);
          end
          m_wr = wr; m_base = host_addr; m_rdata = '0; m_k = 0; m_active = 1;
        end
        if (hg) begin
          if (m_wr) sb[q_addr[0]] = q_data[0];
          else m_rdata[8*m_k +: 8] = sb[q_addr[0]];
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          m_k++;
          m_rr_spi = 0;
          if (q_addr.size() == 0) begin
            m_active = 0;
            m_done = 1;
          end
        end
        if (sg) begin
          sb[m_paddr] = m_pdata;
          m_pend = 0;
          m_rr_spi = 1;
        end
        if (spi_wdata_v) begin
          if (pp && !sg) m_ovf = 1;
          m_pend = 1; m_paddr = spi_addr; m_pdata = spi_wdata;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    spi_addr_v = 0; spi_wdata_v = 0;
    host_write_n = 2'b11; host_read_n = 2'b11;
  endtask

  task automatic spi_wr(input logic [5:0] a, input logic [7:0] d);
    spi_addr = a; spi_wdata = d; spi_wdata_v = 1;
    cyc();
    spi_wdata_v = 0;
    cyc(); cyc();
  endtask

  // Scripted SPI traffic during a host transaction, indexed by cycle.
  bit         sw_en [8];
  logic [5:0] sw_a [8];
  logic [7:0] sw_d [8];
  int         rd_cyc;
  logic [5:0] rd_a;
  logic [7:0] rd_exp;

  task automatic clear_script();
    for (int i = 0; i < 8; i++) begin
      sw_en[i] = 0; sw_a[i] = '0; sw_d[i] = '0;
    end
    rd_cyc = -1; rd_a = '0; rd_exp = '0;
  endtask

  task automatic host_txn(input logic [5:0] a, input logic [31:0] d,
                          input logic [1:0] wn, input logic [1:0] rn,
                          output int lat, output logic [31:0] rd);
    lat = -1; rd = '0;
    host_addr = a; host_wdata = d; host_write_n = wn; host_read_n = rn;
    for (int i = 0; i < 40; i++) begin
      spi_wdata_v = (i < 8) && sw_en[i];
      spi_addr_v  = (i == rd_cyc);
      if (i == rd_cyc) spi_addr = rd_a;
      else if (i < 8 && sw_en[i]) begin
        spi_addr = sw_a[i]; spi_wdata = sw_d[i];
      end
      @(negedge clk);
      if (i == rd_cyc) chk("spi_rd_same_cycle", 32'(spi_rdata), 32'(rd_exp));
      if (host_ready) begin
        lat = i; rd = host_rdata;
        break;
      end
      cyc();
    end
    if (lat < 0) chk("host_ready_timeout", 32'hFFFF_FFFF, 32'd0);
    cyc();
    set_idle();
  endtask

  int          lat;
  logic [31:0] rd;
  bit          h_busy;
  bit          last_ready;

  initial begin
    set_idle();
    rstb = 0;
    @(posedge clk);
    started = 1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_ovf", 32'(spi_ovf), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    cyc();
    rstb = 1;
    cyc(); cyc();
    clear_script();

    host_txn(6'h3E, 32'hDDCCBBAA, 2'b10, 2'b11, lat, rd);
    chk("t1_lat", 32'(lat), 32'd5);
    chk("t1_b3E", 32'(bank[6'h3E]), 32'hAA);
    chk("t1_b3F", 32'(bank[6'h3F]), 32'hBB);
    chk("t1_b00", 32'(bank[6'h00]), 32'hCC);
    chk("t1_b01", 32'(bank[6'h01]), 32'hDD);

    spi_wr(6'h10, 8'h34);
    spi_wr(6'h11, 8'h12);
    spi_wr(6'h05, 8'hC3);
    host_txn(6'h10, 32'h0, 2'b11, 2'b01, lat, rd);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_rdata", rd, 32'h0000_1234);

    rd_cyc = 2; rd_a = 6'h05; rd_exp = 8'hC3;
    host_txn(6'h3E, 32'h0, 2'b11, 2'b10, lat, rd);
    chk("t3_lat", 32'(lat), 32'd6);
    chk("t3_rdata", rd, 32'hDDCCBBAA);
    clear_script();

    sw_en[0] = 1; sw_a[0] = 6'h20; sw_d[0] = 8'h5A;
    host_txn(6'h08, 32'h04030201, 2'b10, 2'b11, lat, rd);
    chk("t4_lat", 32'(lat), 32'd6);
    chk("t4_b20", 32'(bank[6'h20]), 32'h5A);
    chk("t4_b0A", 32'(bank[6'h0A]), 32'h03);
    clear_script();

    sw_en[0] = 1; sw_a[0] = 6'h24; sw_d[0] = 8'h99;
    sw_en[1] = 1; sw_a[1] = 6'h23; sw_d[1] = 8'h77;
    sw_en[2] = 1; sw_a[2] = 6'h25; sw_d[2] = 8'h66;
    host_txn(6'h0C, 32'h0D0C0B0A, 2'b10, 2'b11, lat, rd);
    chk("t5_b24", 32'(bank[6'h24]), 32'h99);
    chk("t5_b23_lost", 32'(bank[6'h23]), 32'h00);
    chk("t5_b25", 32'(bank[6'h25]), 32'h66);
    chk("t5_ovf", 32'(spi_ovf), 32'd1);
    cyc(); cyc();
    chk("t5_ovf_sticky", 32'(spi_ovf), 32'd1);
    clear_script();

    host_addr = 6'h30; host_wdata = 32'h44332211;
    host_write_n = 2'b10; host_read_n = 2'b11;
    cyc(); cyc(); cyc();
    rstb = 0;
    set_idle();
    cyc();
    rstb = 1;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ovf", 32'(spi_ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_ready", 32'(host_ready), 32'd0);
      cyc();
      @(negedge clk);
    end
    chk("t6_b30", 32'(bank[6'h30]), 32'h11);
    chk("t6_b31", 32'(bank[6'h31]), 32'h22);
    chk("t6_b32", 32'(bank[6'h32]), 32'h00);
    cyc();

    h_busy = 0;
    last_ready = 0;
    for (int c = 0; c < 4000; c++) begin
      rstb = $urandom_range(0, 399) != 0;
      ena  = $urandom_range(0, 9) != 0;
      spi_addr    = 6'($urandom);
      spi_wdata   = 8'($urandom);
      spi_addr_v  = $urandom_range(0, 4) == 0;
      spi_wdata_v = $urandom_range(0, 5) == 0;
      if (!rstb) begin
        h_busy = 0;
        host_write_n = 2'b11; host_read_n = 2'b11;
      end else if (!h_busy) begin
        host_write_n = 2'b11; host_read_n = 2'b11;
        if (!last_ready && $urandom_range(0, 2) == 0) begin
          host_addr    = 6'($urandom);
          host_wdata   = $urandom;
          host_write_n = 2'($urandom_range(0, 3));
          host_read_n  = 2'($urandom_range(0, 3));
          h_busy = (host_write_n != 2'b11) || (host_read_n != 2'b11);
        end
      end
      @(negedge clk);
      last_ready = host_ready;
      if (host_ready) h_busy = 0;
      cyc();
    end
    rstb = 1; ena = 1;
    set_idle();
    for (int i = 0; i < 12; i++) cyc();

    for (int i = 0; i < 64; i++)
      chk("bank_final", 32'(bank[i]), 32'(sb[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_bank_arbiter.md
Name: spi_bank_arbiter

Overview:
- Shares one byte-wide, single-port register bank (the AES key/data/result bytes) between two requesters: the SPI register slave and the TinyQV host bus.
- Converts host byte, half-word and word accesses into sequential byte beats.
- Captures SPI write strobes into a pending slot, because the SPI side cannot be stalled.
- Serves SPI read strobes with zero latency.
- Reports a busy flag that feeds the SPI status byte.

Parameters:
ADDR_W, 6, bank byte-address width; addresses wrap modulo 2^ADDR_W

Ports:
clk  in  1  system clock
rstb  in  1  reset, synchronous, active-low
ena  in  1  clock enable; low freezes all state and forces mem_we=0
spi_addr  in  ADDR_W  SPI register address
spi_addr_v  in  1  SPI read-load pulse; spi_rdata must be valid in the same cycle
spi_rdata  out  8  read byte returned to the SPI slave (combinational from mem_rdata)
spi_wdata  in  8  SPI write byte
spi_wdata_v  in  1  SPI write pulse
host_addr  in  ADDR_W  host byte address
host_wdata  in  32  host write data, little-endian
host_write_n  in  2  00 byte, 01 half, 10 word, 11 none
host_read_n  in  2  same encoding as host_write_n
host_rdata  out  32  host read data, zero-extended
host_ready  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W  bank address
mem_we  out  1  bank write enable (bank writes on the clk edge)
mem_wdata  out  8  bank write data
mem_rdata  in  8  bank asynchronous read data
busy  out  1  FSM not in IDLE, or SPI write pending
spi_ovf  out  1  sticky: a pending SPI write was overwritten

Behaviour:
- Reset: rstb=0 at a clk edge takes precedence over ena. Clears FSM to IDLE, the pending slot, the beat counter, rr_last (=HOST), host_rdata=0, host_ready=0 and spi_ovf=0.
  - Combinational outputs after reset: mem_we=0, busy=0.
  - A transaction in flight at reset is abandoned; bytes already written stay in the bank.
- Per-cycle grant, fixed order:
  1. spi_addr_v=1: mem_addr=spi_addr, mem_we=0, spi_rdata=mem_rdata. No state advances for the other requesters.
  2. Else, if an SPI write is pending and (no host beat is pending or rr_last=HOST): write the pending byte, clear the slot, set rr_last=SPI.
  3. Else, if a host beat is pending: perform that beat, set rr_last=HOST.
  4. Else: mem_we=0; mem_addr holds the host latched address.
- SPI write capture: spi_wdata_v=1 latches {spi_addr, spi_wdata} into the pending slot.
  - If the slot is already full and not granted in this cycle, the new value replaces the old one and spi_ovf is set.
  - If the slot is granted in this cycle, the new value loads and no overflow is flagged.
- Host FSM states: IDLE, BEAT, DONE.
  - IDLE: accepts a request when host_write_n!=11 or host_read_n!=11. If both are valid, the write is taken.
    - Latches address, width, data and direction.
    - Sets beats=1/2/4, clears host_rdata, then moves to BEAT.
  - BEAT: each granted beat k accesses address (addr+k) mod 2^ADDR_W.
    - Write beats drive host_wdata[8k+7:8k].
    - Read beats load mem_rdata into host_rdata[8k+7:8k].
    - After the last beat, move to DONE.
    - A beat that is not granted stalls with no change.
  - DONE: host_ready=1 for this cycle only, then return to IDLE. The requester deasserts in the next cycle, so a held request is not re-accepted.
- Uncontended latency, counting request-visible cycle = 0: byte request gives host_ready in cycle 2; half-word in cycle 3; word in cycle 5.
- rr_last alternation guarantees neither the SPI write path nor the host path starves; SPI reads always win.

Optional Feature:
- Macro ARB_HOST_LOCK_EN.
- Defined:
  - Adds input host_lock (1) and output spi_wr_blocked (1, sticky, cleared only by reset).
  - While host_lock=1, spi_wdata_v pulses are discarded at capture and set spi_wr_blocked.
  - An SPI write already pending is still performed.
  - SPI reads are unaffected.
- Undefined: both ports are absent and every SPI write is captured as described above.

Test Plan:
- Host word write addr 0x3E, data 0xDDCCBBAA, no SPI traffic -> bank bytes 0x3E=AA, 0x3F=BB, 0x00=CC, 0x01=DD (wrap); host_ready pulses in cycle 5 only.
- Host half-word read at addr 0x10, with bank 0x10=0x34 and 0x11=0x12 -> host_rdata=0x00001234, host_ready in cycle 3.
- spi_addr_v pulse at addr 0x05 during the second beat of a host word read -> spi_rdata equals bank[0x05] in the same cycle; host beat 2 slips one cycle and host_ready moves to cycle 6; read data is still correct.
- SPI write 0x5A to addr 0x20 pending while a host word write is active -> grants alternate SPI/host; bank[0x20]=0x5A; host_ready in cycle 6.
- Two spi_wdata_v pulses on consecutive cycles while host beats are pending and rr_last=SPI -> only the second byte is written; spi_ovf=1 until rstb=0.
- rstb=0 for one cycle during beat 2 of a word write -> host_ready never pulses; busy=0 and spi_ovf=0 the cycle after reset; bytes 0 and 1 remain in the bank.
